// File: rtl/io_handshake.sv
// Operator handshake for the processor's in/out stall: conditions the confirm
// button, then answers a pending in/out request with a single-cycle sinal pulse.
module io_handshake #(
    parameter int DATA_WIDTH      = 32,
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in,
    input  logic                  out,
    input  logic [DATA_WIDTH-1:0] dado_out,
    input  logic [SW_WIDTH-1:0]   chave,
    input  logic                  botao,
    output logic                  sinal,
    output logic [DATA_WIDTH-1:0] dado_in,
    output logic [DATA_WIDTH-1:0] display,
    output logic                  aguardando
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        ACK,
        WAIT_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic                  btn_db_q, btn_db_d;
    logic                  btn_prev_q, btn_prev_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  op_in_q, op_in_d;
    logic [DATA_WIDTH-1:0] dado_in_q, dado_in_d;
    logic [DATA_WIDTH-1:0] display_q, display_d;
    logic                  sinal_q, sinal_d;
    logic                  aguardando_q, aguardando_d;
    logic                  press;
    logic                  req_dropped;

    // Debounce: the level only moves after DEBOUNCE_CYCLES straight cycles of disagreement.
    always_comb begin
        sync_d     = {sync_q[0], botao};
        btn_db_d   = btn_db_q;
        btn_prev_d = btn_db_q;
        cnt_d      = '0;
        if (sync_q[1] != btn_db_q) begin
            if (cnt_q == CNT_LAST) begin
                btn_db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign press       = btn_db_q & ~btn_prev_q;
    assign req_dropped = op_in_q ? ~in : ~out;

    always_comb begin
        state_d   = state_q;
        op_in_d   = op_in_q;
        dado_in_d = dado_in_q;
        display_d = display_q;
        case (state_q)
            IDLE: begin
                if (in) begin
                    state_d = WAIT_PRESS;
                    op_in_d = 1'b1;
                end else if (out) begin
                    state_d   = WAIT_PRESS;
                    op_in_d   = 1'b0;
                    display_d = dado_out;
                end
            end
            WAIT_PRESS: begin
                if (req_dropped) begin
                    state_d = IDLE;
                end else if (press) begin
                    if (op_in_q) begin
                        dado_in_d = DATA_WIDTH'(chave);
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                // A held button must be let go before another instruction can complete.
                if (!btn_db_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        sinal_d      = (state_d == ACK);
        aguardando_d = (state_d == WAIT_PRESS);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            btn_db_q     <= 1'b0;
            btn_prev_q   <= 1'b0;
            cnt_q        <= '0;
            op_in_q      <= 1'b0;
            dado_in_q    <= '0;
            display_q    <= '0;
            sinal_q      <= 1'b0;
            aguardando_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            btn_db_q     <= btn_db_d;
            btn_prev_q   <= btn_prev_d;
            cnt_q        <= cnt_d;
            op_in_q      <= op_in_d;
            dado_in_q    <= dado_in_d;
            display_q    <= display_d;
            sinal_q      <= sinal_d;
            aguardando_q <= aguardando_d;
        end
    end

    assign sinal      = sinal_q;
    assign dado_in    = dado_in_q;
    assign display    = display_q;
    assign aguardando = aguardando_q;

endmodule

// File: tb/tb_io_handshake.sv
// Bench for io_handshake: cycle table, hand-written corner sequences and a
// randomized run, all checked against a behavioural model of the protocol.
module tb_io_handshake;

    localparam int DW = 32;
    localparam int SW = 16;
    localparam int DB = 4;

    logic          clock = 1'b0;
    logic          reset_s;
    logic          in_s, out_s, botao_s;
    logic [DW-1:0] dado_out_s;
    logic [SW-1:0] chave_s;
    logic          sinal_w, aguardando_w;
    logic [DW-1:0] dado_in_w, display_w;

    always #5 clock = ~clock;

    io_handshake #(
        .DATA_WIDTH     (DW),
        .SW_WIDTH       (SW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock     (clock),
        .reset     (reset_s),
        .in        (in_s),
        .out       (out_s),
        .dado_out  (dado_out_s),
        .chave     (chave_s),
        .botao     (botao_s),
        .sinal     (sinal_w),
        .dado_in   (dado_in_w),
        .display   (display_w),
        .aguardando(aguardando_w)
    );

    int checks = 0;
    int errors = 0;
    int row = 0;
    int pulses = 0;
    int pulse_row = -1;

    // Behavioural model: request kind, post-ack release wait, button history.
    logic          m_hist[$];
    logic          m_db, m_db_prev, m_hold, m_sinal;
    int            m_req;  // 0 none, 1 input pending, 2 output pending
    logic [DW-1:0] m_din, m_disp;

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < DB + 2; i++) m_hist.push_back(1'b0);
        m_db = 0; m_db_prev = 0; m_hold = 0; m_sinal = 0;
        m_req = 0; m_din = '0; m_disp = '0;
    endfunction

    function automatic void model_edge();
        logic press, nsig, all_diff;
        press = m_db & ~m_db_prev;
        nsig  = 1'b0;
        if (m_sinal) m_hold = 1'b1;
        else if (m_hold) begin
            if (!m_db) m_hold = 1'b0;
        end else if (m_req == 0) begin
            if (in_s) m_req = 1;
            else if (out_s) begin m_req = 2; m_disp = dado_out_s; end
        end else if ((m_req == 1 && !in_s) || (m_req == 2 && !out_s)) begin
            m_req = 0;
        end else if (press) begin
            if (m_req == 1) m_din = DW'(chave_s);
            m_req = 0;
            nsig  = 1'b1;
        end
        m_sinal   = nsig;
        m_db_prev = m_db;
        // Level flips once the last DB synchronized samples all disagree with it.
        m_hist.push_front(botao_s);
        all_diff = 1'b1;
        for (int i = 2; i <= DB + 1; i++) if (m_hist[i] == m_db) all_diff = 1'b0;
        if (all_diff) m_db = ~m_db;
        void'(m_hist.pop_back());
    endfunction

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d: got %h expected %h", name, row, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("sinal", DW'(sinal_w), DW'(m_sinal));
        chk("aguardando", DW'(aguardando_w), DW'(m_req != 0));
        chk("dado_in", dado_in_w, m_din);
        chk("display", display_w, m_disp);
        if (sinal_w === 1'b1) begin
            pulses++;
            pulse_row = row;
            $display("txn: sinal row=%0d dado_in=%h display=%h", row, dado_in_w, display_w);
        end
        row++;
    endtask

    task automatic drive(logic a, logic b, logic [DW-1:0] dout, logic [SW-1:0] ch, logic bt);
        in_s = a; out_s = b; dado_out_s = dout; chave_s = ch; botao_s = bt;
    endtask

    task automatic run(int n, logic a, logic b, logic [DW-1:0] dout, logic [SW-1:0] ch, logic bt);
        repeat (n) begin
            drive(a, b, dout, ch, bt);
            step();
        end
    endtask

    typedef struct {
        logic          i_in, i_out;
        logic [DW-1:0] i_dout;
        logic [SW-1:0] i_chave;
        logic          i_botao;
        logic          e_sinal, e_agu;
        logic [DW-1:0] e_din, e_disp;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(logic a, logic b, logic [DW-1:0] dout, logic [SW-1:0] ch,
                                    logic bt, logic es, logic ea, logic [DW-1:0] ed,
                                    logic [DW-1:0] ep);
        vec_t v;
        v.i_in = a; v.i_out = b; v.i_dout = dout; v.i_chave = ch; v.i_botao = bt;
        v.e_sinal = es; v.e_agu = ea; v.e_din = ed; v.e_disp = ep;
        vecs.push_back(v);
    endfunction

    initial begin
        int run_left;
        reset_s = 1'b0;
        drive(0, 0, '0, '0, 0);
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_sinal", DW'(sinal_w), '0);
        chk("reset_aguardando", DW'(aguardando_w), '0);
        chk("reset_dado_in", dado_in_w, '0);
        chk("reset_display", display_w, '0);
        @(negedge clock);
        reset_s = 1'b1;

        // Input capture then output display; button rise on row 1 gives sinal on row 7.
        add_vec(1, 0, '0, 16'hBEEF, 0, 0, 1, 32'h0, 32'h0);
        for (int i = 1; i <= 6; i++) add_vec(1, 0, '0, 16'hBEEF, 1, 0, 1, 32'h0, 32'h0);
        add_vec(1, 0, '0, 16'hBEEF, 1, 1, 0, 32'h0000BEEF, 32'h0);
        add_vec(0, 0, '0, 16'hBEEF, 1, 0, 0, 32'h0000BEEF, 32'h0);
        for (int i = 9; i <= 15; i++) add_vec(0, 0, '0, 16'hBEEF, 0, 0, 0, 32'h0000BEEF, 32'h0);
        add_vec(0, 1, 32'h12345678, 16'h1111, 0, 0, 1, 32'h0000BEEF, 32'h12345678);
        for (int i = 17; i <= 22; i++)
            add_vec(0, 1, 32'h12345678, 16'h1111, 1, 0, 1, 32'h0000BEEF, 32'h12345678);
        add_vec(0, 1, 32'h12345678, 16'h1111, 1, 1, 0, 32'h0000BEEF, 32'h12345678);
        add_vec(0, 0, 32'h12345678, 16'h1111, 1, 0, 0, 32'h0000BEEF, 32'h12345678);
        for (int i = 25; i <= 31; i++)
            add_vec(0, 0, '0, 16'h1111, 0, 0, 0, 32'h0000BEEF, 32'h12345678);

        row = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].i_in, vecs[i].i_out, vecs[i].i_dout, vecs[i].i_chave, vecs[i].i_botao);
            step();
            chk("tbl_sinal", DW'(sinal_w), DW'(vecs[i].e_sinal));
            chk("tbl_aguardando", DW'(aguardando_w), DW'(vecs[i].e_agu));
            chk("tbl_dado_in", dado_in_w, vecs[i].e_din);
            chk("tbl_display", display_w, vecs[i].e_disp);
        end

        // Bounce: toggling every 2 cycles never settles; steady level from row 20.
        row = 0; pulses = 0; pulse_row = -1;
        for (int k = 0; k < 20; k++) run(1, 1, 0, '0, 16'h3333, ((k / 2) % 2) == 0);
        run(15, 1, 0, '0, 16'h3333, 1);
        chk("bounce_pulses", DW'(pulses), 32'd1);
        chk("bounce_pulse_row", DW'(pulse_row), 32'd26);
        run(1, 0, 0, '0, 16'h3333, 1);
        run(8, 0, 0, '0, 16'h3333, 0);

        // Held button across two back-to-back input requests.
        row = 0; pulses = 0; pulse_row = -1;
        run(8, 1, 0, '0, 16'h2222, 1);
        run(1, 0, 0, '0, 16'h2222, 1);
        run(21, 1, 0, '0, 16'h2222, 1);
        chk("held_single", DW'(pulses), 32'd1);
        run(10, 1, 0, '0, 16'h2222, 0);
        run(8, 1, 0, '0, 16'h2222, 1);
        chk("held_second", DW'(pulses), 32'd2);
        chk("held_second_row", DW'(pulse_row), 32'd46);
        run(1, 0, 0, '0, 16'h2222, 1);
        run(8, 0, 0, '0, 16'h2222, 0);

        // in and out together: input wins, display untouched.
        row = 0; pulses = 0;
        run(1, 1, 1, 32'hAAAA5555, 16'h0C0D, 0);
        run(8, 1, 1, 32'hAAAA5555, 16'h0C0D, 1);
        chk("prio_pulses", DW'(pulses), 32'd1);
        chk("prio_display", display_w, 32'h12345678);
        chk("prio_dado_in", dado_in_w, 32'h00000C0D);
        run(1, 0, 0, '0, 16'h0C0D, 1);
        run(8, 0, 0, '0, 16'h0C0D, 0);

        // Output request withdrawn before any press; later press in IDLE is dropped.
        row = 0; pulses = 0;
        run(4, 0, 1, 32'h0BADF00D, 16'h0E0E, 0);
        chk("abort_waiting", DW'(aguardando_w), 32'd1);
        chk("abort_display", display_w, 32'h0BADF00D);
        run(1, 0, 0, '0, 16'h0E0E, 0);
        chk("abort_idle", DW'(aguardando_w), 32'd0);
        run(8, 0, 0, '0, 16'h0E0E, 1);
        run(8, 0, 0, '0, 16'h0E0E, 0);
        chk("abort_pulses", DW'(pulses), 32'd0);
        chk("abort_dado_in", dado_in_w, 32'h00000C0D);

        // Asynchronous reset while waiting with dado_in = 5.
        row = 0; pulses = 0;
        run(1, 1, 0, '0, 16'h0005, 0);
        run(7, 1, 0, '0, 16'h0005, 1);
        run(1, 0, 0, '0, 16'h0005, 1);
        run(8, 0, 0, '0, 16'h0005, 0);
        chk("rst_pre_dado_in", dado_in_w, 32'd5);
        run(3, 1, 0, '0, 16'h0005, 0);
        chk("rst_pre_waiting", DW'(aguardando_w), 32'd1);
        #3 reset_s = 1'b0;
        #1;
        chk("rst_async_sinal", DW'(sinal_w), '0);
        chk("rst_async_aguardando", DW'(aguardando_w), '0);
        chk("rst_async_dado_in", dado_in_w, '0);
        chk("rst_async_display", display_w, '0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_s = 1'b1;
        model_reset();
        run(1, 0, 0, '0, 16'h0005, 0);
        chk("rst_post_idle", DW'(aguardando_w), 32'd0);
        run(1, 1, 0, '0, 16'h0005, 0);
        chk("rst_post_wait", DW'(aguardando_w), 32'd1);
        chk("rst_pulses", DW'(pulses), 32'd1);

        // Randomized traffic against the model.
        row = 0; pulses = 0; run_left = 0;
        repeat (3000) begin
            if (run_left == 0) begin
                botao_s  = ~botao_s;
                run_left = $urandom_range(1, 14);
            end
            run_left--;
            if ($urandom_range(0, 15) == 0) in_s = ~in_s;
            if ($urandom_range(0, 15) == 0) out_s = ~out_s;
            chave_s    = SW'($urandom);
            dado_out_s = $urandom;
            step();
        end
        chk("rand_pulses_seen", DW'(pulses > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
